// File: rtl/riscv_pkg.sv
// Shared types for the instruction-fetch path.
//   ibus_entry_t : one buffered instruction word plus its bus error flag
//   INSTR_BYTES  : pc increment between sequential instruction words
package riscv_pkg;

    localparam int INSTR_BYTES = 4;

    typedef struct packed {
        logic        err;
        logic [31:0] data;
    } ibus_entry_t;

endpackage

// File: rtl/ibus_prefetch_fifo.sv
// Synchronous FIFO holding prefetched instruction words.
//   clk, rstf     : clock, asynchronous active-low reset
//   clear         : empties the FIFO; takes priority over push/pop
//   push, push_entry : write one entry at the tail
//   pop           : drop the head entry
//   head_entry    : current head (combinational, valid when count != 0)
//   count         : number of valid entries, 0..DEPTH
module ibus_prefetch_fifo
    import riscv_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rstf,
    input  logic                         clear,
    input  logic                         push,
    input  ibus_entry_t                  push_entry,
    input  logic                         pop,
    output ibus_entry_t                  head_entry,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int AW = $clog2(DEPTH);

    ibus_entry_t   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or negedge rstf) begin
        if (!rstf) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; count gates every read of it.
    always_ff @(posedge clk) begin
        if (push && !clear) mem[wr_ptr] <= push_entry;
    end

    assign head_entry = mem[rd_ptr];

endmodule

// File: rtl/ibus_prefetch.sv
// Instruction prefetch buffer in front of the core's instruction bus.
// Answers core fetches that match the sequential stream combinationally
// from a FIFO and keeps up to DEPTH sequential reads in flight on an
// in-order pipelined memory port. A fetch to any other pc flushes the
// buffer, marks in-flight reads as stale and restarts at the new pc.
//   clk, rstf              : clock, asynchronous active-low reset
//   iBus_cmd_valid/_pc     : core fetch request
//   iBus_cmd_ready         : request hit this cycle
//   iBus_rsp_ready/_err/_instr : same-cycle response for a hit
//   mem_cmd_valid/_ready/_addr : read request to memory
//   mem_rsp_valid/_data/_err   : in-order read response
module ibus_prefetch
    import riscv_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        rstf,
    input  logic        iBus_cmd_valid,
    input  logic [31:0] iBus_cmd_payload_pc,
    output logic        iBus_cmd_ready,
    output logic        iBus_rsp_ready,
    output logic        iBus_rsp_err,
    output logic [31:0] iBus_rsp_instr,
    output logic        mem_cmd_valid,
    input  logic        mem_cmd_ready,
    output logic [31:0] mem_cmd_addr,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_data,
    input  logic        mem_rsp_err
);

    localparam int          CW      = $clog2(DEPTH + 1);
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);
    localparam logic [31:0] STEP    = 32'(INSTR_BYTES);

    logic          run_q;
    logic [31:0]   fetch_pc;
    logic [31:0]   head_pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] outstanding_nxt;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] drop_cnt_nxt;
    logic [CW-1:0] fifo_count;
    ibus_entry_t   head_entry;
    ibus_entry_t   rsp_entry;

    logic pc_match, hit, miss, credit_ok, accept, drop, push;

    assign pc_match = (iBus_cmd_payload_pc == head_pc);
    assign hit      = iBus_cmd_valid && pc_match && (fifo_count != '0);
    assign miss     = iBus_cmd_valid && !pc_match;

    // Credit covers buffered words plus every read still in flight,
    // including stale ones awaiting drop, so the FIFO can never overflow.
    assign credit_ok = ({1'b0, fifo_count} + {1'b0, outstanding}) < DEPTH_C;

    // run_q holds off the first request until the cycle after reset release,
    // which also keeps mem_cmd_valid low throughout reset.
    assign mem_cmd_valid = run_q && credit_ok && !miss;
    assign mem_cmd_addr  = fetch_pc;
    assign accept        = mem_cmd_valid && mem_cmd_ready;

    // A response in the redirect cycle belongs to the old stream.
    assign drop = mem_rsp_valid && (miss || (drop_cnt != '0));
    assign push = mem_rsp_valid && !drop;

    always_comb begin
        outstanding_nxt = outstanding;
        if (accept) outstanding_nxt = outstanding_nxt + 1'b1;
        // Saturate so a response left over from before reset cannot wrap.
        if (mem_rsp_valid && outstanding_nxt != '0)
            outstanding_nxt = outstanding_nxt - 1'b1;
    end

    // Stale reads stay counted in outstanding until they return, so on a
    // redirect the reads still in flight after this cycle are exactly the
    // ones to discard, earlier pending drops included.
    always_comb begin
        drop_cnt_nxt = drop_cnt;
        if (miss)      drop_cnt_nxt = outstanding_nxt;
        else if (drop) drop_cnt_nxt = drop_cnt - 1'b1;
    end

    always_ff @(posedge clk or negedge rstf) begin
        if (!rstf) begin
            run_q       <= 1'b0;
            fetch_pc    <= RESET_PC;
            head_pc     <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            run_q       <= 1'b1;
            outstanding <= outstanding_nxt;
            drop_cnt    <= drop_cnt_nxt;
            if (miss) begin
                fetch_pc <= iBus_cmd_payload_pc;
                head_pc  <= iBus_cmd_payload_pc;
            end else begin
                if (accept) fetch_pc <= fetch_pc + STEP;
                if (hit)    head_pc  <= head_pc + STEP;
            end
        end
    end

    assign rsp_entry = '{err: mem_rsp_err, data: mem_rsp_data};

    ibus_prefetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rstf       (rstf),
        .clear      (miss),
        .push       (push),
        .push_entry (rsp_entry),
        .pop        (hit),
        .head_entry (head_entry),
        .count      (fifo_count)
    );

    assign iBus_cmd_ready = hit;
    assign iBus_rsp_ready = hit;
    assign iBus_rsp_instr = hit ? head_entry.data : 32'h0;
    assign iBus_rsp_err   = hit && head_entry.err;

endmodule

// File: tb/tb_ibus_prefetch.sv
module tb_ibus_prefetch;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstf;

    // dut: DEPTH=4, RESET_PC=0, driven by a variable-latency memory model
    logic        cmd_valid, cmd_ready, rsp_ready, rsp_err;
    logic [31:0] cmd_pc, rsp_instr;
    logic        mem_cmd_valid, mem_cmd_ready, mem_rsp_valid, mem_rsp_err;
    logic [31:0] mem_cmd_addr, mem_rsp_data;

    // dut2: RESET_PC near the top of the address space, 1-cycle memory
    logic        cmd_valid2, cmd_ready2, rsp_ready2, rsp_err2;
    logic [31:0] cmd_pc2, rsp_instr2;
    logic        mcv2, mcr2, mrv2, mre2;
    logic [31:0] maddr2, mdata2;
    assign mcr2 = 1'b1;
    assign mre2 = 1'b0;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          lat     = 1;
    logic [31:0] err_addr = 32'h1;

    ibus_prefetch #(.DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk(clk), .rstf(rstf),
        .iBus_cmd_valid(cmd_valid), .iBus_cmd_payload_pc(cmd_pc),
        .iBus_cmd_ready(cmd_ready), .iBus_rsp_ready(rsp_ready),
        .iBus_rsp_err(rsp_err), .iBus_rsp_instr(rsp_instr),
        .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready),
        .mem_cmd_addr(mem_cmd_addr), .mem_rsp_valid(mem_rsp_valid),
        .mem_rsp_data(mem_rsp_data), .mem_rsp_err(mem_rsp_err)
    );

    ibus_prefetch #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dut2 (
        .clk(clk), .rstf(rstf),
        .iBus_cmd_valid(cmd_valid2), .iBus_cmd_payload_pc(cmd_pc2),
        .iBus_cmd_ready(cmd_ready2), .iBus_rsp_ready(rsp_ready2),
        .iBus_rsp_err(rsp_err2), .iBus_rsp_instr(rsp_instr2),
        .mem_cmd_valid(mcv2), .mem_cmd_ready(mcr2),
        .mem_cmd_addr(maddr2), .mem_rsp_valid(mrv2),
        .mem_rsp_data(mdata2), .mem_rsp_err(mre2)
    );

    // In-order memory: a read accepted in cycle c answers in cycle c+lat.
    typedef struct packed { int due; logic [31:0] d; logic e; } mreq_t;
    mreq_t mq[$];
    int    mcyc;

    always @(posedge clk or negedge rstf) begin
        if (!rstf) begin
            mq.delete();
            mcyc = 0;
            mem_rsp_valid <= 1'b0;
            mem_rsp_data  <= 32'h0;
            mem_rsp_err   <= 1'b0;
        end else begin
            if (mem_cmd_valid && mem_cmd_ready)
                mq.push_back('{mcyc + lat - 1, mem_cmd_addr ^ 32'hA5A5_0000,
                               mem_cmd_addr == err_addr});
            mem_rsp_valid <= 1'b0;
            if (mq.size() != 0 && mq[0].due == mcyc) begin
                mem_rsp_valid <= 1'b1;
                mem_rsp_data  <= mq[0].d;
                mem_rsp_err   <= mq[0].e;
                mq.delete(0);
            end
            mcyc = mcyc + 1;
        end
    end

    logic [31:0] iss2[$];
    always @(posedge clk or negedge rstf) begin
        if (!rstf) begin
            mrv2   <= 1'b0;
            mdata2 <= 32'h0;
            iss2.delete();
        end else begin
            mrv2   <= mcv2;
            mdata2 <= maddr2 ^ 32'hA5A5_0000;
            if (mcv2) iss2.push_back(maddr2);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Leaves the bench in cycle 0 after release (at the negedge).
    task automatic do_reset();
        @(negedge clk);
        cmd_valid = 1'b0; cmd_pc = 32'h0; cmd_valid2 = 1'b0; cmd_pc2 = 32'h0;
        mem_cmd_ready = 1'b1; lat = 1; err_addr = 32'h1;
        rstf = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rstf = 1'b1;
    endtask

    // Request pc until it hits (bounded), check the returned word, advance.
    task automatic fetch(input bit sel, input logic [31:0] pc,
                         input logic [31:0] exp_d, input logic exp_e);
        int w   = 0;
        bit got = 1'b0;
        while (!got && w < 20) begin
            if (sel) begin cmd_valid2 = 1'b1; cmd_pc2 = pc; end
            else     begin cmd_valid  = 1'b1; cmd_pc  = pc; end
            #1;
            if ((sel ? cmd_ready2 : cmd_ready) == 1'b1) begin
                got = 1'b1;
                chk($sformatf("hit %h data", pc), sel ? rsp_instr2 : rsp_instr, exp_d);
                chk($sformatf("hit %h err", pc), sel ? rsp_err2 : rsp_err, exp_e);
                chk($sformatf("hit %h rsp_ready", pc), sel ? rsp_ready2 : rsp_ready, 1);
            end
            @(negedge clk);
            w++;
        end
        chk($sformatf("hit %h within bound", pc), got, 1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1);
    end

    initial begin
        rstf = 1'b0;
        cmd_valid = 1'b1; cmd_pc = 32'h4; cmd_valid2 = 1'b0; cmd_pc2 = 32'h0;
        mem_cmd_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        // ---- reset state: outputs quiet, address shows RESET_PC
        chk("rst cmd_ready", cmd_ready, 0);
        chk("rst rsp_ready", rsp_ready, 0);
        chk("rst rsp_instr", rsp_instr, 0);
        chk("rst rsp_err", rsp_err, 0);
        chk("rst mem_cmd_valid", mem_cmd_valid, 0);
        chk("rst mem_cmd_addr", mem_cmd_addr, 32'h0);
        chk("rst mem_cmd_valid2", mcv2, 0);
        chk("rst mem_cmd_addr2", maddr2, 32'hFFFF_FFF8);

        // ---- sequential fetch, 1-cycle memory: first hit in cycle 3
        do_reset();
        cmd_valid = 1'b1; cmd_pc = 32'h0; #1;
        chk("seq c0 ready", cmd_ready, 0);
        chk("seq c0 mem_cmd_valid", mem_cmd_valid, 0);
        @(negedge clk); #1;
        chk("seq c1 ready", cmd_ready, 0);
        chk("seq c1 mem_cmd_valid", mem_cmd_valid, 1);
        chk("seq c1 mem_cmd_addr", mem_cmd_addr, 32'h0);
        @(negedge clk); #1;
        chk("seq c2 ready", cmd_ready, 0);
        @(negedge clk); #1;
        chk("seq c3 ready", cmd_ready, 1);
        chk("seq c3 data", rsp_instr, 32'hA5A5_0000);
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            cmd_pc = 32'(i * 4); #1;
            chk($sformatf("seq c%0d ready", i + 3), cmd_ready, 1);
            chk($sformatf("seq c%0d data", i + 3), rsp_instr, 32'(i * 4) ^ 32'hA5A5_0000);
        end
        chk("seq c6 run-ahead addr", mem_cmd_addr, 32'h14);

        // ---- memory stall with core waiting at 0x10
        do_reset();
        mem_cmd_ready = 1'b0;
        cmd_valid = 1'b1; cmd_pc = 32'h10; #1;
        chk("stall c0 ready", cmd_ready, 0);
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk); #1;
            chk($sformatf("stall c%0d ready", i), cmd_ready, 0);
            chk($sformatf("stall c%0d addr", i), mem_cmd_addr, 32'h10);
            chk($sformatf("stall c%0d mem_cmd_valid", i), mem_cmd_valid, 1);
        end
        @(negedge clk);
        mem_cmd_ready = 1'b1;
        fetch(1'b0, 32'h10, 32'hA5A5_0010, 1'b0);

        // ---- redirect to 0x100 with 3 reads in flight, rsp in miss cycle
        do_reset();
        lat = 3;
        repeat (4) @(negedge clk);
        cmd_valid = 1'b1; cmd_pc = 32'h100; #1;
        chk("redir c4 outstanding", dut.outstanding, 3);
        chk("redir c4 mem_cmd_valid", mem_cmd_valid, 0);
        chk("redir c4 ready", cmd_ready, 0);
        @(negedge clk); #1;
        chk("redir c5 drop_cnt", dut.drop_cnt, 2);
        chk("redir c5 fifo_count", dut.fifo_count, 0);
        chk("redir c5 mem_cmd_addr", mem_cmd_addr, 32'h100);
        @(negedge clk);
        @(negedge clk); #1;
        chk("redir c7 drop_cnt", dut.drop_cnt, 0);
        fetch(1'b0, 32'h100, 32'hA5A5_0100, 1'b0);
        fetch(1'b0, 32'h104, 32'hA5A5_0104, 1'b0);
        fetch(1'b0, 32'h108, 32'hA5A5_0108, 1'b0);

        // ---- fill with core idle; hit plus push keeps count
        do_reset();
        repeat (5) @(negedge clk);
        cmd_valid = 1'b1; cmd_pc = 32'h0; #1;
        chk("fill c5 mem_cmd_valid", mem_cmd_valid, 0);
        chk("fill c5 ready", cmd_ready, 1);
        chk("fill c5 data", rsp_instr, 32'hA5A5_0000);
        @(negedge clk);
        cmd_valid = 1'b0; #1;
        chk("fill c6 count after push+pop", dut.fifo_count, 3);
        chk("fill c6 mem_cmd_valid", mem_cmd_valid, 1);
        chk("fill c6 mem_cmd_addr", mem_cmd_addr, 32'h10);
        @(negedge clk);
        @(negedge clk); #1;
        chk("fill c8 count", dut.fifo_count, 4);
        chk("fill c8 mem_cmd_valid", mem_cmd_valid, 0);
        for (int i = 1; i <= 4; i++)
            fetch(1'b0, 32'(i * 4), 32'(i * 4) ^ 32'hA5A5_0000, 1'b0);

        // ---- bus error on 0x8 travels with its word
        do_reset();
        err_addr = 32'h8;
        fetch(1'b0, 32'h0, 32'hA5A5_0000, 1'b0);
        fetch(1'b0, 32'h4, 32'hA5A5_0004, 1'b0);
        fetch(1'b0, 32'h8, 32'hA5A5_0008, 1'b1);
        fetch(1'b0, 32'hC, 32'hA5A5_000C, 1'b0);
        fetch(1'b0, 32'h10, 32'hA5A5_0010, 1'b0);

        // ---- address wrap from the top of memory
        do_reset();
        fetch(1'b1, 32'hFFFF_FFF8, 32'h5A5A_FFF8, 1'b0);
        fetch(1'b1, 32'hFFFF_FFFC, 32'h5A5A_FFFC, 1'b0);
        fetch(1'b1, 32'h0, 32'hA5A5_0000, 1'b0);
        fetch(1'b1, 32'h4, 32'hA5A5_0004, 1'b0);
        chk("wrap issue count", iss2.size() >= 4, 1);
        if (iss2.size() >= 4) begin
            chk("wrap issue 0", iss2[0], 32'hFFFF_FFF8);
            chk("wrap issue 1", iss2[1], 32'hFFFF_FFFC);
            chk("wrap issue 2", iss2[2], 32'h0);
            chk("wrap issue 3", iss2[3], 32'h4);
        end
        chk("wrap no flush", dut2.drop_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
